// File: rtl/cv32e41p_rf_writeback_pkg.sv
// rtl/cv32e41p_rf_writeback_pkg.sv - shared defaults for the register-file writeback stage
//
// Purpose: default parameter values and a pointer-width helper shared by
//          cv32e41p_rf_writeback and cv32e41p_rf_wb_queue.
// Ports:   none (package).

package cv32e41p_rf_writeback_pkg;

    localparam int unsigned RF_WB_ADDR_WIDTH = 5;
    localparam int unsigned RF_WB_DATA_WIDTH = 32;
    localparam int unsigned RF_WB_DEPTH      = 2;

    // Width of a wrap-around index into a power-of-two deep queue.
    function automatic int unsigned rf_wb_ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cv32e41p_rf_wb_queue.sv
// rtl/cv32e41p_rf_wb_queue.sv - in-order FIFO of pending load destinations
//
// Purpose: holds the destination addresses of issued-but-unanswered loads in
//          issue order, and exposes every entry so the scoreboard can compare
//          decode/EX addresses against all of them in parallel.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push_i/push_waddr_i enqueue a destination (taken when not full, or when
//                       a pop happens in the same cycle)
//   pop_i               dequeue the head (ignored when empty)
//   full_o/empty_o      occupancy flags, from state only
//   head_waddr_o        destination at the head of the queue
//   entry_valid_o       per-entry valid bits
//   entry_waddr_o       per-entry destination addresses

module cv32e41p_rf_wb_queue
    import cv32e41p_rf_writeback_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RF_WB_ADDR_WIDTH,
    parameter int unsigned DEPTH      = RF_WB_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push_i,
    input  logic [ADDR_WIDTH-1:0]               push_waddr_i,
    input  logic                                pop_i,
    output logic                                full_o,
    output logic                                empty_o,
    output logic [ADDR_WIDTH-1:0]               head_waddr_o,
    output logic [DEPTH-1:0]                    entry_valid_o,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0]    entry_waddr_o
);

    localparam int unsigned     PTR_W    = rf_wb_ptr_width(DEPTH);
    localparam int unsigned     CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0]                 valid_q, valid_d;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [PTR_W-1:0]                 rptr_q, rptr_d;
    logic [PTR_W-1:0]                 wptr_q, wptr_d;
    logic [CNT_W-1:0]                 count_q, count_d;

    logic full, empty, push_en, pop_en;

    always_comb begin
        full    = (count_q == FULL_CNT);
        empty   = (count_q == '0);
        pop_en  = pop_i && !empty;
        // When full, the slot being pushed into is the one being freed by the pop.
        push_en = push_i && (!full || pop_en);

        valid_d = valid_q;
        waddr_d = waddr_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;

        // Pop is applied first so a simultaneous push into the same slot wins.
        if (pop_en) begin
            valid_d[rptr_q] = 1'b0;
            rptr_d          = rptr_q + PTR_W'(1);
        end
        if (push_en) begin
            valid_d[wptr_q] = 1'b1;
            waddr_d[wptr_q] = push_waddr_i;
            wptr_d          = wptr_q + PTR_W'(1);
        end

        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            waddr_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            waddr_q <= waddr_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    assign full_o        = full;
    assign empty_o       = empty;
    assign head_waddr_o  = waddr_q[rptr_q];
    assign entry_valid_o = valid_q;
    assign entry_waddr_o = waddr_q;

endmodule

// File: rtl/cv32e41p_rf_writeback.sv
// rtl/cv32e41p_rf_writeback.sv - register-file writeback stage with load scoreboard
//
// Purpose: registers EX results onto RF write port A, matches in-order load
//          responses to their queued destinations on RF write port B, and
//          reports pending destinations so decode stalls on RAW hazards and EX
//          cannot overtake an outstanding load to the same register.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ex_we_i/ex_waddr_i/ex_wdata_i  EX result; ex_stall_o refuses it this cycle
//   lsu_issue_i/lsu_issue_waddr_i  load issue; lsu_issue_ready_o = queue not full
//   lsu_rvalid_i/lsu_rdata_i       load data, returned in issue order
//   raddr_{a,b,c}_i/busy_{a,b,c}_o decode read addresses and their hazard flags
//   waddr/wdata/we_{a,b}_o         RF write ports A (EX) and B (loads)
//   err_o                          one-cycle pulse, cycle after a protocol violation

module cv32e41p_rf_writeback
    import cv32e41p_rf_writeback_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RF_WB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = RF_WB_DATA_WIDTH,
    parameter int unsigned DEPTH      = RF_WB_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ex_we_i,
    input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
    input  logic [DATA_WIDTH-1:0] ex_wdata_i,
    output logic                  ex_stall_o,

    input  logic                  lsu_issue_i,
    input  logic [ADDR_WIDTH-1:0] lsu_issue_waddr_i,
    output logic                  lsu_issue_ready_o,
    input  logic                  lsu_rvalid_i,
    input  logic [DATA_WIDTH-1:0] lsu_rdata_i,

    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_c_i,
    output logic                  busy_a_o,
    output logic                  busy_b_o,
    output logic                  busy_c_o,

    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_a_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o,
    output logic                  we_b_o,

    output logic                  err_o
);

    logic                             q_push, q_pop;
    logic                             q_full, q_empty;
    logic [ADDR_WIDTH-1:0]            q_head_waddr;
    logic [DEPTH-1:0]                 q_entry_valid;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] q_entry_waddr;

    logic                  we_a_q, we_a_d;
    logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d;
    logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d;
    logic                  we_b_q, we_b_d;
    logic [ADDR_WIDTH-1:0] waddr_b_q, waddr_b_d;
    logic [DATA_WIDTH-1:0] wdata_b_q, wdata_b_d;
    logic                  err_q, err_d;

    logic ex_stall, ex_accept;

    cv32e41p_rf_wb_queue #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_queue (
        .clk           (clk),
        .rst           (rst),
        .push_i        (q_push),
        .push_waddr_i  (lsu_issue_waddr_i),
        .pop_i         (q_pop),
        .full_o        (q_full),
        .empty_o       (q_empty),
        .head_waddr_o  (q_head_waddr),
        .entry_valid_o (q_entry_valid),
        .entry_waddr_o (q_entry_waddr)
    );

    function automatic logic queue_hit(
        input logic [DEPTH-1:0]                 vld,
        input logic [DEPTH-1:0][ADDR_WIDTH-1:0] wa,
        input logic [ADDR_WIDTH-1:0]            addr
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (wa[i] == addr)) hit = 1'b1;
        end
        return hit;
    endfunction

    // A register is busy while a load to it is queued or while either write
    // port is still presenting it (RF contents become visible a cycle later).
    function automatic logic reg_busy(
        input logic [DEPTH-1:0]                 vld,
        input logic [DEPTH-1:0][ADDR_WIDTH-1:0] wa,
        input logic                             wea,
        input logic [ADDR_WIDTH-1:0]            waa,
        input logic                             web,
        input logic [ADDR_WIDTH-1:0]            wab,
        input logic [ADDR_WIDTH-1:0]            addr
    );
        return (addr != '0) &&
               (queue_hit(vld, wa, addr) || (wea && (waa == addr)) || (web && (wab == addr)));
    endfunction

    always_comb begin
        q_pop  = lsu_rvalid_i && !q_empty;
        // A full queue still accepts an issue when a response frees the head slot.
        q_push = lsu_issue_i && (!q_full || q_pop);

        // EX must not write a register an older load is still going to write.
        ex_stall  = ex_we_i && (ex_waddr_i != '0) &&
                    queue_hit(q_entry_valid, q_entry_waddr, ex_waddr_i);
        ex_accept = ex_we_i && !ex_stall;

        we_a_d    = ex_accept && (ex_waddr_i != '0);
        waddr_a_d = we_a_d ? ex_waddr_i : waddr_a_q;
        wdata_a_d = we_a_d ? ex_wdata_i : wdata_a_q;

        // x0 loads occupy a queue slot for ordering but never reach the RF.
        we_b_d    = q_pop && (q_head_waddr != '0);
        waddr_b_d = we_b_d ? q_head_waddr : waddr_b_q;
        wdata_b_d = we_b_d ? lsu_rdata_i : wdata_b_q;

        err_d = (lsu_issue_i && q_full && !q_pop) || (lsu_rvalid_i && q_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_a_q    <= 1'b0;
            waddr_a_q <= '0;
            wdata_a_q <= '0;
            we_b_q    <= 1'b0;
            waddr_b_q <= '0;
            wdata_b_q <= '0;
            err_q     <= 1'b0;
        end else begin
            we_a_q    <= we_a_d;
            waddr_a_q <= waddr_a_d;
            wdata_a_q <= wdata_a_d;
            we_b_q    <= we_b_d;
            waddr_b_q <= waddr_b_d;
            wdata_b_q <= wdata_b_d;
            err_q     <= err_d;
        end
    end

    assign ex_stall_o        = ex_stall;
    assign lsu_issue_ready_o = !q_full;

    assign busy_a_o = reg_busy(q_entry_valid, q_entry_waddr, we_a_q, waddr_a_q,
                               we_b_q, waddr_b_q, raddr_a_i);
    assign busy_b_o = reg_busy(q_entry_valid, q_entry_waddr, we_a_q, waddr_a_q,
                               we_b_q, waddr_b_q, raddr_b_i);
    assign busy_c_o = reg_busy(q_entry_valid, q_entry_waddr, we_a_q, waddr_a_q,
                               we_b_q, waddr_b_q, raddr_c_i);

    assign we_a_o    = we_a_q;
    assign waddr_a_o = waddr_a_q;
    assign wdata_a_o = wdata_a_q;
    assign we_b_o    = we_b_q;
    assign waddr_b_o = waddr_b_q;
    assign wdata_b_o = wdata_b_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_cv32e41p_rf_writeback.sv
// tb/tb_cv32e41p_rf_writeback.sv - self-checking bench for cv32e41p_rf_writeback

module tb_cv32e41p_rf_writeback;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_we_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_stall_o;
    logic        lsu_issue_i;
    logic [4:0]  lsu_issue_waddr_i;
    logic        lsu_issue_ready_o;
    logic        lsu_rvalid_i;
    logic [31:0] lsu_rdata_i;
    logic [4:0]  raddr_a_i, raddr_b_i, raddr_c_i;
    logic        busy_a_o, busy_b_o, busy_c_o;
    logic [4:0]  waddr_a_o, waddr_b_o;
    logic [31:0] wdata_a_o, wdata_b_o;
    logic        we_a_o, we_b_o;
    logic        err_o;

    cv32e41p_rf_writeback #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_we_i           (ex_we_i),
        .ex_waddr_i        (ex_waddr_i),
        .ex_wdata_i        (ex_wdata_i),
        .ex_stall_o        (ex_stall_o),
        .lsu_issue_i       (lsu_issue_i),
        .lsu_issue_waddr_i (lsu_issue_waddr_i),
        .lsu_issue_ready_o (lsu_issue_ready_o),
        .lsu_rvalid_i      (lsu_rvalid_i),
        .lsu_rdata_i       (lsu_rdata_i),
        .raddr_a_i         (raddr_a_i),
        .raddr_b_i         (raddr_b_i),
        .raddr_c_i         (raddr_c_i),
        .busy_a_o          (busy_a_o),
        .busy_b_o          (busy_b_o),
        .busy_c_o          (busy_c_o),
        .waddr_a_o         (waddr_a_o),
        .wdata_a_o         (wdata_a_o),
        .we_a_o            (we_a_o),
        .waddr_b_o         (waddr_b_o),
        .wdata_b_o         (wdata_b_o),
        .we_b_o            (we_b_o),
        .err_o             (err_o)
    );

    always #5 clk = ~clk;

    // Inputs applied in a cycle and the outputs expected at that cycle's negedge.
    typedef struct {
        logic [31:0] rst, exwe, exa, exd, iss, isa, rv, rd, ra, rb;
        logic [31:0] stall, rdy, bsa, bsb, wea, wa, wda, web, wb, wdb, err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: queue of pending load destinations plus the write
    // each port is presenting this cycle.
    logic [4:0]  mq[$];
    logic        m_we_a, m_we_b, m_err;
    logic [4:0]  m_wa, m_wb;
    logic [31:0] m_wda, m_wdb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit in_q(input logic [4:0] a);
        foreach (mq[i]) if (mq[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_busy(input logic [4:0] r);
        return (r != 0) && (in_q(r) || (m_we_a && m_wa == r) || (m_we_b && m_wb == r));
    endfunction

    task automatic model_step();
        bit         full, pop, push, stall;
        logic [4:0] head;
        if (rst) begin
            mq.delete();
            m_we_a = 0; m_wa = 0; m_wda = 0;
            m_we_b = 0; m_wb = 0; m_wdb = 0;
            m_err  = 0;
        end else begin
            full  = (mq.size() == DEPTH);
            pop   = lsu_rvalid_i && (mq.size() != 0);
            push  = lsu_issue_i && (!full || pop);
            head  = (mq.size() != 0) ? mq[0] : 5'd0;
            stall = ex_we_i && (ex_waddr_i != 0) && in_q(ex_waddr_i);
            m_err = (lsu_issue_i && full && !pop) || (lsu_rvalid_i && mq.size() == 0);
            m_we_a = ex_we_i && !stall && (ex_waddr_i != 0);
            if (m_we_a) begin m_wa = ex_waddr_i; m_wda = ex_wdata_i; end
            m_we_b = pop && (head != 0);
            if (m_we_b) begin m_wb = head; m_wdb = lsu_rdata_i; end
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(lsu_issue_waddr_i);
        end
    endtask

    task automatic cmp_model(input int cyc);
        bit e_stall;
        e_stall = ex_we_i && (ex_waddr_i != 0) && in_q(ex_waddr_i);
        chk($sformatf("rnd%0d stall", cyc),   ex_stall_o,        e_stall);
        chk($sformatf("rnd%0d ready", cyc),   lsu_issue_ready_o, mq.size() != DEPTH);
        chk($sformatf("rnd%0d busy_a", cyc),  busy_a_o,          m_busy(raddr_a_i));
        chk($sformatf("rnd%0d busy_b", cyc),  busy_b_o,          m_busy(raddr_b_i));
        chk($sformatf("rnd%0d busy_c", cyc),  busy_c_o,          m_busy(raddr_c_i));
        chk($sformatf("rnd%0d we_a", cyc),    we_a_o,            m_we_a);
        chk($sformatf("rnd%0d waddr_a", cyc), waddr_a_o,         m_wa);
        chk($sformatf("rnd%0d wdata_a", cyc), wdata_a_o,         m_wda);
        chk($sformatf("rnd%0d we_b", cyc),    we_b_o,            m_we_b);
        chk($sformatf("rnd%0d waddr_b", cyc), waddr_b_o,         m_wb);
        chk($sformatf("rnd%0d wdata_b", cyc), wdata_b_o,         m_wdb);
        chk($sformatf("rnd%0d err", cyc),     err_o,             m_err);
    endtask

    task automatic drive_vec(input vec_t v);
        rst               = v.rst[0];
        ex_we_i           = v.exwe[0];
        ex_waddr_i        = v.exa[4:0];
        ex_wdata_i        = v.exd;
        lsu_issue_i       = v.iss[0];
        lsu_issue_waddr_i = v.isa[4:0];
        lsu_rvalid_i      = v.rv[0];
        lsu_rdata_i       = v.rd;
        raddr_a_i         = v.ra[4:0];
        raddr_b_i         = v.rb[4:0];
        raddr_c_i         = v.rb[4:0];
    endtask

    task automatic cmp_vec(input int k, input vec_t v);
        chk($sformatf("v%0d stall", k),   ex_stall_o,        v.stall);
        chk($sformatf("v%0d ready", k),   lsu_issue_ready_o, v.rdy);
        chk($sformatf("v%0d busy_a", k),  busy_a_o,          v.bsa);
        chk($sformatf("v%0d busy_b", k),  busy_b_o,          v.bsb);
        chk($sformatf("v%0d busy_c", k),  busy_c_o,          v.bsb);
        chk($sformatf("v%0d we_a", k),    we_a_o,            v.wea);
        chk($sformatf("v%0d waddr_a", k), waddr_a_o,         v.wa);
        chk($sformatf("v%0d wdata_a", k), wdata_a_o,         v.wda);
        chk($sformatf("v%0d we_b", k),    we_b_o,            v.web);
        chk($sformatf("v%0d waddr_b", k), waddr_b_o,         v.wb);
        chk($sformatf("v%0d wdata_b", k), wdata_b_o,         v.wdb);
        chk($sformatf("v%0d err", k),     err_o,             v.err);
    endtask

    localparam logic [31:0] D5 = 32'h1234_5678;

    initial begin
        //            rst ex a  data  is a  rv data ra rb | st rd ba bb wa a dat we b dat err
        vecs.push_back('{1,0,0,0,     0,0, 0,0,    5,0,  0,1,0,0, 0,0,0,    0,0,0,     0});
        // EX write x5, busy only in the port-A cycle
        vecs.push_back('{0,1,5,D5,    0,0, 0,0,    5,0,  0,1,0,0, 0,0,0,    0,0,0,     0});
        vecs.push_back('{0,0,0,0,     0,0, 0,0,    5,0,  0,1,1,0, 1,5,D5,   0,0,0,     0});
        vecs.push_back('{0,0,0,0,     0,0, 0,0,    5,0,  0,1,0,0, 0,5,D5,   0,0,0,     0});
        // loads x3, x7 fill the queue; third issue errors; in-order responses
        vecs.push_back('{0,0,0,0,     1,3, 0,0,    3,7,  0,1,0,0, 0,5,D5,   0,0,0,     0});
        vecs.push_back('{0,0,0,0,     1,7, 0,0,    3,7,  0,1,1,0, 0,5,D5,   0,0,0,     0});
        vecs.push_back('{0,0,0,0,     1,9, 0,0,    3,7,  0,0,1,1, 0,5,D5,   0,0,0,     0});
        vecs.push_back('{0,0,0,0,     0,0, 0,0,    3,9,  0,0,1,0, 0,5,D5,   0,0,0,     1});
        vecs.push_back('{0,0,0,0,     0,0, 1,'hA,  3,7,  0,0,1,1, 0,5,D5,   0,0,0,     0});
        vecs.push_back('{0,0,0,0,     0,0, 1,'hB,  3,7,  0,1,1,1, 0,5,D5,   1,3,'hA,   0});
        vecs.push_back('{0,0,0,0,     0,0, 0,0,    3,7,  0,1,0,1, 0,5,D5,   1,7,'hB,   0});
        vecs.push_back('{0,0,0,0,     0,0, 0,0,    3,7,  0,1,0,0, 0,5,D5,   0,7,'hB,   0});
        // WAW: EX x9 stalls behind load x9
        vecs.push_back('{0,0,0,0,     1,9, 0,0,    9,0,  0,1,0,0, 0,5,D5,   0,7,'hB,   0});
        vecs.push_back('{0,1,9,'h99,  0,0, 0,0,    9,0,  1,1,1,0, 0,5,D5,   0,7,'hB,   0});
        vecs.push_back('{0,1,9,'h99,  0,0, 1,'h55, 9,0,  1,1,1,0, 0,5,D5,   0,7,'hB,   0});
        vecs.push_back('{0,1,9,'h99,  0,0, 0,0,    9,0,  0,1,1,0, 0,5,D5,   1,9,'h55,  0});
        vecs.push_back('{0,0,0,0,     0,0, 0,0,    9,0,  0,1,1,0, 1,9,'h99, 0,9,'h55,  0});
        vecs.push_back('{0,0,0,0,     0,0, 0,0,    9,0,  0,1,0,0, 0,9,'h99, 0,9,'h55,  0});
        // full queue: simultaneous issue x4 and response
        vecs.push_back('{0,0,0,0,     1,3, 0,0,    4,3,  0,1,0,0, 0,9,'h99, 0,9,'h55,  0});
        vecs.push_back('{0,0,0,0,     1,7, 0,0,    4,3,  0,1,0,1, 0,9,'h99, 0,9,'h55,  0});
        vecs.push_back('{0,0,0,0,     1,4, 1,'hC,  4,3,  0,0,0,1, 0,9,'h99, 0,9,'h55,  0});
        vecs.push_back('{0,0,0,0,     0,0, 0,0,    4,3,  0,0,1,1, 0,9,'h99, 1,3,'hC,   0});
        vecs.push_back('{0,0,0,0,     0,0, 1,'hD,  4,7,  0,0,1,1, 0,9,'h99, 0,3,'hC,   0});
        vecs.push_back('{0,0,0,0,     0,0, 1,'hE,  4,7,  0,1,1,1, 0,9,'h99, 1,7,'hD,   0});
        vecs.push_back('{0,0,0,0,     0,0, 0,0,    4,7,  0,1,1,0, 0,9,'h99, 1,4,'hE,   0});
        vecs.push_back('{0,0,0,0,     0,0, 0,0,    4,7,  0,1,0,0, 0,9,'h99, 0,4,'hE,   0});
        // x0 load and EX, followed by load x2
        vecs.push_back('{0,1,0,'hF0,  1,0, 0,0,    0,2,  0,1,0,0, 0,9,'h99, 0,4,'hE,   0});
        vecs.push_back('{0,0,0,0,     1,2, 0,0,    0,2,  0,1,0,0, 0,9,'h99, 0,4,'hE,   0});
        vecs.push_back('{0,0,0,0,     0,0, 1,'h11, 0,2,  0,0,0,1, 0,9,'h99, 0,4,'hE,   0});
        vecs.push_back('{0,0,0,0,     0,0, 1,'h22, 0,2,  0,1,0,1, 0,9,'h99, 0,4,'hE,   0});
        vecs.push_back('{0,0,0,0,     0,0, 0,0,    0,2,  0,1,0,1, 0,9,'h99, 1,2,'h22,  0});
        vecs.push_back('{0,0,0,0,     0,0, 0,0,    0,2,  0,1,0,0, 0,9,'h99, 0,2,'h22,  0});
        // reset with two loads pending, then a stray response
        vecs.push_back('{0,0,0,0,     1,3, 0,0,    3,7,  0,1,0,0, 0,9,'h99, 0,2,'h22,  0});
        vecs.push_back('{0,0,0,0,     1,7, 0,0,    3,7,  0,1,1,0, 0,9,'h99, 0,2,'h22,  0});
        vecs.push_back('{1,0,0,0,     0,0, 0,0,    3,7,  0,0,1,1, 0,9,'h99, 0,2,'h22,  0});
        vecs.push_back('{0,0,0,0,     0,0, 1,'h77, 3,7,  0,1,0,0, 0,0,0,    0,0,0,     0});
        vecs.push_back('{0,0,0,0,     0,0, 0,0,    3,7,  0,1,0,0, 0,0,0,    0,0,0,     1});
        vecs.push_back('{0,0,0,0,     0,0, 0,0,    3,7,  0,1,0,0, 0,0,0,    0,0,0,     0});

        drive_vec(vecs[0]);
        repeat (2) begin
            @(negedge clk);
            model_step();
            @(posedge clk);
            #1;
        end

        foreach (vecs[k]) begin
            drive_vec(vecs[k]);
            @(negedge clk);
            cmp_vec(k, vecs[k]);
            model_step();
            @(posedge clk);
            #1;
        end

        for (int c = 0; c < 600; c++) begin
            rst               = ($urandom_range(63, 0) == 0);
            ex_we_i           = $urandom_range(1, 0) == 1;
            ex_waddr_i        = 5'($urandom_range(7, 0));
            ex_wdata_i        = $urandom;
            lsu_issue_i       = $urandom_range(9, 0) < 4;
            lsu_issue_waddr_i = 5'($urandom_range(7, 0));
            lsu_rvalid_i      = $urandom_range(9, 0) < 4;
            lsu_rdata_i       = $urandom;
            raddr_a_i         = 5'($urandom_range(7, 0));
            raddr_b_i         = 5'($urandom_range(7, 0));
            raddr_c_i         = 5'($urandom_range(7, 0));
            @(negedge clk);
            cmp_model(c);
            model_step();
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
